// File: rtl/layer1_scheduler.sv
// ---------------------------------------------------------------------------
// layer1_scheduler
//   Evaluates one layer of LUT neurons by sharing a single 2^FANIN:1 table
//   lookup across all neurons, one neuron per clock.
//   An input vector is accepted in IDLE and latched into a holding register.
//   EVAL then walks cnt over the neurons and fills result[]. DONE presents
//   result until the consumer takes it.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data     input vector handshake (M0)
//   out_valid/out_ready/out_data  result vector handshake (M1, bit n = neuron n)
//   cfg_we/cfg_addr/cfg_data      truth-table write; bit k = output for index k
//   busy          high while in EVAL or DONE
// ---------------------------------------------------------------------------

// Fixed fan-in wiring for one neuron: gathers its six inputs, MSB first.
module layer1_fanin #(
   parameter int IN_W      = 25,
   parameter int FANIN     = 6,
   parameter int NEURON_ID = 0
) (
   input  logic [IN_W-1:0]  m0,
   output logic [FANIN-1:0] idx
);
   // Only some M0 bits feed each neuron; fold the whole vector here so the
   // remaining bits are not reported as dangling.
   logic unused_m0;
   assign unused_m0 = ^m0;

   always_comb begin
      idx = '0;
      case (NEURON_ID)
         0: idx = FANIN'({m0[16], m0[13], m0[12], m0[5], m0[3], m0[1]});
         1: idx = FANIN'({m0[24], m0[17], m0[15], m0[13], m0[6], m0[2]});
         2: idx = FANIN'({m0[24], m0[21], m0[20], m0[7], m0[6], m0[4]});
         3: idx = FANIN'({m0[19], m0[15], m0[14], m0[13], m0[12], m0[6]});
         4: idx = FANIN'({m0[21], m0[13], m0[7], m0[5], m0[3], m0[2]});
         default: idx = '0;
      endcase
   end
endmodule

module layer1_scheduler #(
   parameter int NEURONS = 5,
   parameter int IN_W    = 25,
   parameter int FANIN   = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NEURONS-1:0]      out_data,
   input  logic                    cfg_we,
   input  logic [2:0]              cfg_addr,
   input  logic [(1<<FANIN)-1:0]   cfg_data,
   output logic                    busy
);
   localparam int TT_W = 1 << FANIN;

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

   state_e                         state_q, state_d;
   logic [2:0]                     cnt_q, cnt_d;
   logic [IN_W-1:0]                hold_q, hold_d;
   logic [NEURONS-1:0]             result_q, result_d;
   logic [NEURONS-1:0][TT_W-1:0]   tt_q, tt_d;
   logic                           in_ready_q, in_ready_d;
   logic                           out_valid_q, out_valid_d;
   logic                           busy_q, busy_d;

   // Per-neuron table indices, all computed from the held vector.
   logic [NEURONS-1:0][FANIN-1:0]  idx_all;

   for (genvar g = 0; g < NEURONS; g++) begin : g_fanin
      layer1_fanin #(
         .IN_W      (IN_W),
         .FANIN     (FANIN),
         .NEURON_ID (g)
      ) u_fanin (
         .m0  (hold_q),
         .idx (idx_all[g])
      );
   end

   // The shared lookup reads the registered table, so a write landing on
   // the same edge only affects later lookups.
   logic lut_bit;
   assign lut_bit = tt_q[cnt_q][idx_all[cnt_q]];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      result_d = result_q;
      tt_d     = tt_q;

      if (cfg_we && ({1'b0, cfg_addr} < 4'(NEURONS)))
         tt_d[cfg_addr] = cfg_data;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               hold_d  = in_data;
               cnt_d   = '0;
               state_d = EVAL;
            end
         end
         EVAL: begin
            result_d[cnt_q] = lut_bit;
            // cnt parks on the last neuron rather than wrapping past it.
            if (cnt_q == 3'(NEURONS-1))
               state_d = DONE;
            else
               cnt_d = cnt_q + 3'd1;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Status outputs are registered from the next state.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         result_q    <= '0;
         tt_q        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         result_q    <= result_d;
         tt_q        <= tt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = result_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_layer1_scheduler.sv
// ---------------------------------------------------------------------------
// tb_layer1_scheduler
//   Directed vectors with hand-computed results for layer1_scheduler.
// ---------------------------------------------------------------------------
module tb_layer1_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_data;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [63:0] cfg_data;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   layer1_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [63:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   // Send one vector, check latency, optional DONE stall and mid-EVAL table2
   // write (lands on the edge that evaluates neuron 2), then handshake out.
   task automatic run_vec(input string tag, input logic [24:0] d, input logic [4:0] exp,
                          input int hold, input bit midcfg);
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1; in_data = d;
      tick();
      in_valid = 1'b0; in_data = 25'($urandom);
      chk({tag, "_busy"}, busy, 1);
      for (int k = 1; k <= 5; k++) begin
         if (k == 3 && midcfg) begin
            cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 64'h0;
         end
         tick();
         cfg_we = 1'b0;
         if (k < 5) chk($sformatf("%s_early_valid%0d", tag, k), out_valid, 0);
      end
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_out_data"}, out_data, exp);
      for (int h = 0; h < hold; h++) begin
         in_valid = ~in_valid; in_data = 25'($urandom);
         tick();
         chk($sformatf("%s_hold_valid%0d", tag, h), out_valid, 1);
         chk($sformatf("%s_hold_data%0d", tag, h), out_data, exp);
         chk($sformatf("%s_hold_rdy%0d", tag, h), in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_post_valid"}, out_valid, 0);
      chk({tag, "_post_rdy"}, in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit glitch;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      tick();
      chk("rst_release_rdy", in_ready, 1);

      run_vec("zero_tt", 25'h1FFFFFF, 5'b00000, 0, 0);

      for (int n = 0; n < 5; n++) cfg_write(3'(n), 64'hFFFF_FFFF_FFFF_FFFF);
      run_vec("ones", 25'h0A5A5A5, 5'b11111, 0, 0);
      run_vec("ones_hold", 25'h0123456, 5'b11111, 10, 0);

      cfg_write(3'd0, 64'h2);
      for (int n = 1; n < 5; n++) cfg_write(3'(n), 64'h0);
      run_vec("t0_bit1", 25'h0000002, 5'b00001, 0, 0);
      run_vec("t0_zero", 25'h0000000, 5'b00000, 0, 0);

      // Bits 19,15,14,13,12,6 -> idx N0=24 N1=14 N2=2 N3=63 N4=16.
      cfg_write(3'd0, 64'h1 << 24);
      cfg_write(3'd1, 64'h1 << 14);
      cfg_write(3'd2, 64'h1 << 3);
      cfg_write(3'd3, 64'h1 << 63);
      cfg_write(3'd4, 64'h1 << 16);
      run_vec("map", 25'h008F040, 5'b11011, 0, 0);

      // Reset in the third EVAL cycle.
      in_valid = 1'b1; in_data = 25'h008F040;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", out_data, 0);
      rst = 1'b0;
      tick();
      chk("mid_rst_rdy", in_ready, 1);
      glitch = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) glitch = 1'b1;
         tick();
      end
      chk("mid_rst_no_pulse", glitch, 0);
      run_vec("tt_cleared", 25'h008F040, 5'b00000, 0, 0);

      for (int a = 5; a < 8; a++) cfg_write(3'(a), 64'hFFFF_FFFF_FFFF_FFFF);
      run_vec("oor_addr", 25'h1FFFFFF, 5'b00000, 0, 0);

      cfg_write(3'd2, 64'hFFFF_FFFF_FFFF_FFFF);
      run_vec("midcfg_old", 25'h155AA55, 5'b00100, 0, 1);
      run_vec("midcfg_new", 25'h155AA55, 5'b00000, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
